// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - light-code inputs and checker outputs of traffic_light_monitor
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       i_light_ns;
    logic [1:0]       i_light_ew;
    logic             i_err_clr;
    logic [2:0]       o_phase;
    logic             o_locked;
    logic             o_err_illegal;
    logic             o_err_conflict;
    logic             o_err_seq;
    logic             o_err_stuck;
    logic             o_err_any;
    logic [CNT_W-1:0] o_cycle_cnt;

    modport master (
        output i_light_ns, i_light_ew, i_err_clr,
        input  o_phase, o_locked, o_err_illegal, o_err_conflict, o_err_seq,
               o_err_stuck, o_err_any, o_cycle_cnt
    );

    modport slave (
        input  i_light_ns, i_light_ew, i_err_clr,
        output o_phase, o_locked, o_err_illegal, o_err_conflict, o_err_seq,
               o_err_stuck, o_err_any, o_cycle_cnt
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase-sequence checker for traffic_light_controller
// Dwell (stuck-phase) check is built only when TRAFFIC_MON_STUCK_CHECK_EN is defined.
module traffic_light_monitor #(
    parameter int CNT_W     = 8,
    parameter int MAX_DWELL = 16,
    parameter int DWELL_W   = 5
) (
    input logic                     i_clk,
    input logic                     i_reset_n,
    traffic_light_monitor_if.slave  bus
);
    typedef enum logic [2:0] {
        PH_ALL_RED = 3'd0,
        PH_NS_G    = 3'd1,
        PH_NS_Y    = 3'd2,
        PH_EW_G    = 3'd3,
        PH_EW_Y    = 3'd4,
        PH_INVALID = 3'd7
    } phase_t;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t           r_state, w_state_next;
    phase_t           r_phase, w_phase_next, w_dec;
    logic             r_err_illegal, r_err_conflict, r_err_seq, r_err_stuck, r_err_any;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             w_illegal, w_conflict, w_code_err, w_changed, w_legal;
    logic             w_seq_err, w_cnt_inc, w_stuck_hit;
    logic             w_ill_next, w_conf_next, w_seq_next, w_stuck_next;

    always_comb begin
        w_illegal  = (bus.i_light_ns == 2'b11) || (bus.i_light_ew == 2'b11);
        w_conflict = !w_illegal && (bus.i_light_ns != 2'b00) && (bus.i_light_ew != 2'b00);
        w_code_err = w_illegal || w_conflict;
        case ({bus.i_light_ns, bus.i_light_ew})
            4'b0000: w_dec = PH_ALL_RED;
            4'b1000: w_dec = PH_NS_G;
            4'b0100: w_dec = PH_NS_Y;
            4'b0010: w_dec = PH_EW_G;
            4'b0001: w_dec = PH_EW_Y;
            default: w_dec = PH_INVALID;
        endcase
        w_changed = (w_dec != r_phase);
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_legal      = 1'b1;
        w_seq_err    = 1'b0;
        w_cnt_inc    = 1'b0;
        if (w_code_err) begin
            w_state_next = ST_IDLE;
            w_phase_next = PH_INVALID;
        end else begin
            w_phase_next = w_dec;
            case (r_state)
                ST_IDLE: begin
                    if (w_dec == PH_ALL_RED)
                        w_state_next = ST_LOCKED;
                end
                default: begin
                    // Any drop to ALL_RED is a controller reset and always legal
                    if (w_changed && (w_dec != PH_ALL_RED)) begin
                        case (r_phase)
                            PH_ALL_RED: w_legal = (w_dec == PH_NS_G);
                            PH_NS_G:    w_legal = (w_dec == PH_NS_Y);
                            PH_NS_Y:    w_legal = (w_dec == PH_EW_G);
                            PH_EW_G:    w_legal = (w_dec == PH_EW_Y);
                            PH_EW_Y:    w_legal = (w_dec == PH_NS_G);
                            default:    w_legal = 1'b0;
                        endcase
                        w_seq_err = !w_legal;
                        w_cnt_inc = (r_phase == PH_EW_Y) && (w_dec == PH_NS_G);
                    end
                end
            endcase
        end
    end

`ifdef TRAFFIC_MON_STUCK_CHECK_EN
    logic [DWELL_W-1:0] r_dwell, w_dwell_next;

    always_comb begin
        w_dwell_next = '0;
        w_stuck_hit  = 1'b0;
        if ((r_state == ST_LOCKED) && !w_code_err && !w_changed && (w_dec != PH_ALL_RED)) begin
            if (r_dwell < DWELL_W'(MAX_DWELL)) begin
                w_dwell_next = r_dwell + 1'b1;
                w_stuck_hit  = (r_dwell == DWELL_W'(MAX_DWELL - 1));
            end else begin
                w_dwell_next = r_dwell;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_dwell <= '0;
        else
            r_dwell <= w_dwell_next;
    end
`else
    assign w_stuck_hit = 1'b0;
`endif

    // err_clr drops old flags, but an error seen on the same edge still lands
    always_comb begin
        w_ill_next   = (!bus.i_err_clr && r_err_illegal)  || w_illegal;
        w_conf_next  = (!bus.i_err_clr && r_err_conflict) || w_conflict;
        w_seq_next   = (!bus.i_err_clr && r_err_seq)      || w_seq_err;
        w_stuck_next = (!bus.i_err_clr && r_err_stuck)    || w_stuck_hit;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_phase        <= PH_ALL_RED;
            r_err_illegal  <= 1'b0;
            r_err_conflict <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_stuck    <= 1'b0;
            r_err_any      <= 1'b0;
            r_cycle_cnt    <= '0;
        end else begin
            r_state        <= w_state_next;
            r_phase        <= w_phase_next;
            r_err_illegal  <= w_ill_next;
            r_err_conflict <= w_conf_next;
            r_err_seq      <= w_seq_next;
            r_err_stuck    <= w_stuck_next;
            r_err_any      <= w_ill_next || w_conf_next || w_seq_next || w_stuck_next;
            r_cycle_cnt    <= r_cycle_cnt + CNT_W'(w_cnt_inc);
        end
    end

    assign bus.o_phase        = r_phase;
    assign bus.o_locked       = (r_state == ST_LOCKED);
    assign bus.o_err_illegal  = r_err_illegal;
    assign bus.o_err_conflict = r_err_conflict;
    assign bus.o_err_seq      = r_err_seq;
    assign bus.o_err_stuck    = r_err_stuck;
    assign bus.o_err_any      = r_err_any;
    assign bus.o_cycle_cnt    = r_cycle_cnt;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed vector table, corner sequences and random run against a phase-rule model
module tb_traffic_light_monitor;
    localparam int CNT_W     = 2;
    localparam int MAX_DWELL = 4;
    localparam int DWELL_W   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_light_monitor_if #(.CNT_W(CNT_W)) bus ();

    traffic_light_monitor #(
        .CNT_W(CNT_W), .MAX_DWELL(MAX_DWELL), .DWELL_W(DWELL_W)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // errs = {illegal, conflict, seq, stuck}
    typedef struct {
        logic [1:0] ns;
        logic [1:0] ew;
        logic       clr;
        logic [2:0] phase;
        logic       locked;
        logic [3:0] errs;
        logic [1:0] cnt;
    } vec_t;

    // Reference model state
    int m_phase;
    bit m_locked;
    bit m_ill, m_conf, m_seq, m_stuck;
    int m_cnt;
    int m_dwell;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] ns, input logic [1:0] ew, input logic clr);
        bus.i_light_ns = ns;
        bus.i_light_ew = ew;
        bus.i_err_clr  = clr;
        @(posedge clk);
        #1;
        bus.i_err_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_phase = 0; m_locked = 0; m_cnt = 0; m_dwell = 0;
        m_ill = 0; m_conf = 0; m_seq = 0; m_stuck = 0;
    endtask

    function automatic int decode(input logic [1:0] ns, input logic [1:0] ew);
        if (ns == 2'b00 && ew == 2'b00) return 0;
        if (ns == 2'b10 && ew == 2'b00) return 1;
        if (ns == 2'b01 && ew == 2'b00) return 2;
        if (ns == 2'b00 && ew == 2'b10) return 3;
        if (ns == 2'b00 && ew == 2'b01) return 4;
        return 7;
    endfunction

    task automatic model_step(input logic [1:0] ns, input logic [1:0] ew, input logic clr);
        int p;
        bit legal;
        p = decode(ns, ew);
        if (clr) begin m_ill = 0; m_conf = 0; m_seq = 0; m_stuck = 0; end
        if (p == 7) begin
            if (ns == 2'b11 || ew == 2'b11) m_ill = 1; else m_conf = 1;
            m_phase = 7; m_locked = 0; m_dwell = 0;
        end else if (!m_locked) begin
            m_phase = p; m_dwell = 0;
            if (p == 0) m_locked = 1;
        end else begin
            legal = (p == m_phase) || (p == 0) || (m_phase == 0 && p == 1) ||
                    (m_phase >= 1 && p == (m_phase % 4) + 1);
            if (!legal) m_seq = 1;
            if (m_phase == 4 && p == 1) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (p != m_phase || p == 0) m_dwell = 0;
            else if (m_dwell < MAX_DWELL) begin
                m_dwell++;
`ifdef TRAFFIC_MON_STUCK_CHECK_EN
                if (m_dwell == MAX_DWELL) m_stuck = 1;
`endif
            end
            m_phase = p;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".phase"},    8'(bus.o_phase),        8'(m_phase));
        chk({tag, ".locked"},   8'(bus.o_locked),       8'(m_locked));
        chk({tag, ".illegal"},  8'(bus.o_err_illegal),  8'(m_ill));
        chk({tag, ".conflict"}, 8'(bus.o_err_conflict), 8'(m_conf));
        chk({tag, ".seq"},      8'(bus.o_err_seq),      8'(m_seq));
        chk({tag, ".stuck"},    8'(bus.o_err_stuck),    8'(m_stuck));
        chk({tag, ".any"},      8'(bus.o_err_any),      8'(m_ill | m_conf | m_seq | m_stuck));
        chk({tag, ".cnt"},      8'(bus.o_cycle_cnt),    8'(m_cnt));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".phase"},  8'(bus.o_phase), 8'd0);
        chk({tag, ".locked"}, 8'(bus.o_locked), 8'd0);
        chk({tag, ".errs"},   8'({bus.o_err_illegal, bus.o_err_conflict, bus.o_err_seq,
                                  bus.o_err_stuck, bus.o_err_any}), 8'd0);
        chk({tag, ".cnt"},    8'(bus.o_cycle_cnt), 8'd0);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("reset");
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vt[$];
    logic [1:0] pair_ns[5] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0] pair_ew[5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};

    initial begin
        int ctrl, hold, r;
        logic [1:0] ns, ew;
        logic clr;

        bus.i_light_ns = 2'b00;
        bus.i_light_ew = 2'b00;
        bus.i_err_clr  = 1'b0;
        model_reset();

        // ns, ew, clr, phase, locked, errs, cnt
        vt.push_back('{2'b00, 2'b00, 0, 3'd0, 1, 4'b0000, 2'd0});
        vt.push_back('{2'b10, 2'b00, 0, 3'd1, 1, 4'b0000, 2'd0});
        vt.push_back('{2'b01, 2'b00, 0, 3'd2, 1, 4'b0000, 2'd0});
        vt.push_back('{2'b00, 2'b10, 0, 3'd3, 1, 4'b0000, 2'd0});
        vt.push_back('{2'b00, 2'b01, 0, 3'd4, 1, 4'b0000, 2'd0});
        vt.push_back('{2'b10, 2'b00, 0, 3'd1, 1, 4'b0000, 2'd1});
        vt.push_back('{2'b00, 2'b10, 0, 3'd3, 1, 4'b0010, 2'd1});
        vt.push_back('{2'b00, 2'b10, 1, 3'd3, 1, 4'b0000, 2'd1});
        vt.push_back('{2'b11, 2'b00, 0, 3'd7, 0, 4'b1000, 2'd1});
        vt.push_back('{2'b10, 2'b10, 0, 3'd7, 0, 4'b1100, 2'd1});
        vt.push_back('{2'b00, 2'b00, 0, 3'd0, 1, 4'b1100, 2'd1});
        vt.push_back('{2'b10, 2'b00, 0, 3'd1, 1, 4'b1100, 2'd1});
        vt.push_back('{2'b01, 2'b00, 0, 3'd2, 1, 4'b1100, 2'd1});
        vt.push_back('{2'b00, 2'b10, 0, 3'd3, 1, 4'b1100, 2'd1});
        vt.push_back('{2'b10, 2'b00, 1, 3'd1, 1, 4'b0010, 2'd1});
        for (int c = 0; c < 3; c++) begin
            vt.push_back('{2'b01, 2'b00, 0, 3'd2, 1, 4'b0010, 2'(c + 1)});
            vt.push_back('{2'b00, 2'b10, 0, 3'd3, 1, 4'b0010, 2'(c + 1)});
            vt.push_back('{2'b00, 2'b01, 0, 3'd4, 1, 4'b0010, 2'(c + 1)});
            vt.push_back('{2'b10, 2'b00, 0, 3'd1, 1, 4'b0010, 2'(c + 2)});
        end
        vt.push_back('{2'b11, 2'b11, 0, 3'd7, 0, 4'b1010, 2'd0});
        vt.push_back('{2'b10, 2'b00, 1, 3'd1, 0, 4'b0000, 2'd0});
        vt.push_back('{2'b00, 2'b10, 0, 3'd3, 0, 4'b0000, 2'd0});
        vt.push_back('{2'b00, 2'b00, 0, 3'd0, 1, 4'b0000, 2'd0});
        vt.push_back('{2'b00, 2'b01, 0, 3'd4, 1, 4'b0010, 2'd0});
        vt.push_back('{2'b00, 2'b00, 0, 3'd0, 1, 4'b0010, 2'd0});

        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].ns, vt[i].ew, vt[i].clr);
            chk($sformatf("vec%0d.phase", i),  8'(bus.o_phase),       8'(vt[i].phase));
            chk($sformatf("vec%0d.locked", i), 8'(bus.o_locked),      8'(vt[i].locked));
            chk($sformatf("vec%0d.errs", i),
                8'({bus.o_err_illegal, bus.o_err_conflict, bus.o_err_seq, bus.o_err_stuck}),
                8'(vt[i].errs));
            chk($sformatf("vec%0d.any", i),    8'(bus.o_err_any),     8'(|vt[i].errs));
            chk($sformatf("vec%0d.cnt", i),    8'(bus.o_cycle_cnt),   8'(vt[i].cnt));
        end

        // Reset asserted mid NS_Y, then the first sample is judged from IDLE
        reset_now();
        step(2'b00, 2'b00, 0); model_step(2'b00, 2'b00, 0);
        step(2'b10, 2'b00, 0); model_step(2'b10, 2'b00, 0);
        step(2'b01, 2'b00, 0); model_step(2'b01, 2'b00, 0);
        check_model("pre_rst");
        reset_now();
        step(2'b00, 2'b10, 0); model_step(2'b00, 2'b10, 0);
        chk("post_rst.phase",  8'(bus.o_phase),   8'd3);
        chk("post_rst.locked", 8'(bus.o_locked),  8'd0);
        chk("post_rst.any",    8'(bus.o_err_any), 8'd0);

        // Dwell corner: held NS_G and long ALL_RED
        reset_now();
        step(2'b00, 2'b00, 0);
        step(2'b10, 2'b00, 0);
        for (int k = 1; k <= 3; k++) step(2'b10, 2'b00, 0);
        chk("dwell3.stuck", 8'(bus.o_err_stuck), 8'd0);
        step(2'b10, 2'b00, 0);
`ifdef TRAFFIC_MON_STUCK_CHECK_EN
        chk("dwell4.stuck", 8'(bus.o_err_stuck), 8'd1);
        chk("dwell4.any",   8'(bus.o_err_any),   8'd1);
`else
        chk("dwell4.stuck", 8'(bus.o_err_stuck), 8'd0);
        chk("dwell4.any",   8'(bus.o_err_any),   8'd0);
`endif
        step(2'b00, 2'b00, 1);
        for (int k = 0; k < 20; k++) begin
            step(2'b00, 2'b00, 0);
            chk("allred_hold.stuck", 8'(bus.o_err_stuck), 8'd0);
        end
        chk("allred_hold.locked", 8'(bus.o_locked), 8'd1);

        // Randomised controller-like traffic against the model
        reset_now();
        ctrl = 0;
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            clr = ($urandom_range(0, 15) == 0);
            if (r < 2) begin
                reset_now();
                ctrl = 0;
                continue;
            end else if (r < 9) begin
                ns = 2'($urandom_range(0, 3));
                ew = 2'($urandom_range(0, 3));
            end else if (r < 13) begin
                ctrl = 0;
                ns = pair_ns[0];
                ew = pair_ew[0];
            end else begin
                if (hold > 0) hold--;
                else begin
                    if (r < 17) ctrl = $urandom_range(0, 4);
                    else ctrl = (ctrl == 0) ? 1 : (ctrl % 4) + 1;
                    hold = $urandom_range(0, 6);
                end
                ns = pair_ns[ctrl];
                ew = pair_ew[ctrl];
            end
            step(ns, ew, clr);
            model_step(ns, ew, clr);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
